riscv_multicycle: RTL and testbench
===================================

Name: riscv_multicycle

Overview:
- Parametrised multicycle RV32I core and the successor to the single-cycle core.
- Uses one shared instruction/data memory port with a req/ready handshake, so it tolerates wait states from real SRAM or bus bridges.
- Each instruction runs through an FSM of 3-5 states; the datapath reuses one ALU across states.
- Instruction subset: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal. New in this generation: bne, lui, and a configurable register count (RV32E).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NREGS, 32, register count; legal values 32 (RV32I) or 16 (RV32E)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
mem_req  out  1  memory access request; held until accepted
mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req
mem_addr  out  32  byte address, word aligned; stable while mem_req
mem_wdata  out  32  store data; stable while mem_req
mem_ready  in  1  access completes in a cycle where mem_req and mem_ready are both high
mem_rdata  in  32  read data, valid in the completing cycle
retire  out  1  one-cycle pulse in the last state of each instruction
illegal  out  1  sticky illegal-instruction flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n sampled low at a rising edge).
- Reset values: PC=RESET_PC, state=FETCH, mem_req=0, mem_we=0, retire=0, illegal=0, all registers 0. Reset mid-access drops mem_req on the next edge; no completion is assumed.
- Storage: x0 reads 0 and ignores writes. Registers are indexed by rd/rs[$clog2(NREGS)-1:0].
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, LUI, ALUWB, BRANCH, JAL, HALT.
- FETCH: mem_req=1, mem_addr=PC. On ready: Instr<=mem_rdata, OldPC<=PC, PC<=PC+4, go to DECODE.
- DECODE: A<=rs1, B<=rs2, ALUOut<=OldPC+immB/J. Branch on opcode: lw/sw->MEMADR; R->EXECR; I-ALU->EXECI; lui->LUI; beq/bne->BRANCH; jal->JAL; other->illegal handling.
- MEMADR: ALUOut<=A+imm (I or S form); go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, addr=ALUOut. On ready: Data<=mem_rdata, go to MEMWB.
- MEMWB: rd<=Data, retire=1, go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, wdata=B. On ready: retire=1, go to FETCH.
- EXECR / EXECI: ALUOut<=ALU(A, B or immI). sub is selected only for R-type with funct7[5]=1.
- LUI: ALUOut<={Instr[31:12],12'b0}, go to ALUWB.
- ALUWB: rd<=ALUOut, retire=1, go to FETCH.
- BRANCH: beq takes when A==B; bne (funct3 001) takes when A!=B. If taken, PC<=ALUOut. retire=1, go to FETCH.
- JAL: PC<=ALUOut, rd<=OldPC+4, retire=1, go to FETCH.
- ALU: 32-bit, wraps modulo 2^32. slt/slti are signed compares producing 0 or 1.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R/I/lui 4, beq/bne 3, jal 3. Each ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- While stalled, mem_addr, mem_we and mem_wdata are held constant.
- PC wraps 32'hFFFF_FFFC -> 0.

Optional Feature:
- Macro: RISCV_ILLEGAL_TRAP_EN.
- Trap conditions: unknown opcode or funct3, or register index >= NREGS (RV32E).
- Defined: a trap condition in DECODE sets illegal=1 and enters HALT. HALT never issues mem_req and is left only by reset.
- Undefined: the instruction behaves as a NOP (DECODE->FETCH, retire=1), illegal stays 0, and out-of-range register indices are truncated.

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams: OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_BRANCH, OP_JAL
  - the state_t enum
  - the alu_op_t enum: ADD, SUB, AND, OR, SLT
  - the imm_src_t enum: I, S, B, J, U
- Sub-module riscv_mc_regfile: 2 async reads, 1 sync write, x0 hardwired, parametrised NREGS.
- ALU and immediate extender are inline functions in the package.

Test Plan:
1. Zero-wait memory with program addi x2,x0,5; addi x3,x0,20; add x4,x2,x3; sw x4,100(x0): store at addr 0x64 with wdata 25; retire pulses at cycles 4, 8, 12, 16 after reset release.
2. mem_ready random at 50% on the same program: identical final state; addr/we/wdata hold steady while stalled.
3. beq x0,x0,+8 then bne x0,x0,+8: first sets PC=OldPC+8 in 3 cycles; second falls through to PC+4.
4. lui x5,0x12345 then jal x1,-4: x5=0x12345000; x1=OldPC+4; PC=OldPC-4.
5. reset_n low for 1 cycle during a stalled MEMWRITE: mem_req is 0 next cycle, PC=RESET_PC, no write completes.
6. With RISCV_ILLEGAL_TRAP_EN and NREGS=16, fetch add x17,x1,x2: illegal=1, FSM in HALT, mem_req stays 0. Without the macro: retire pulses and the next fetch is at PC+4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types, opcodes and datapath helpers for the multicycle RV32I core.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, LUI, ALUWB, BRANCH, JAL, HALT
    } state_t;

    typedef enum logic [2:0] { ADD, SUB, AND, OR, SLT } alu_op_t;

    typedef enum logic [2:0] { I, S, B, J, U } imm_src_t;

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            SLT:     return {31'b0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] immext(input imm_src_t src, input logic [31:7] ins);
        case (src)
            S:       return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            B:       return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            J:       return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            U:       return {ins[31:12], 12'b0};
            default: return {{20{ins[31]}}, ins[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_regfile.sv
// Register file: two async reads, one sync write, x0 hardwired to zero.
module riscv_mc_regfile
    import riscv_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [31:0]              rd1,
    output logic [31:0]              rd2,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [31:0]              wd
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/riscv_multicycle.sv
// Multicycle RV32I/RV32E core with one shared req/ready memory port.
// Define RISCV_ILLEGAL_TRAP_EN to halt on illegal instructions instead of treating them as NOPs.
module riscv_multicycle
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        retire,
    output logic        illegal
);

    localparam int RW = $clog2(NREGS);

    state_t      state, next_state;
    logic [31:0] pc, old_pc, instr, a_reg, b_reg, alu_out, data_reg;
    logic [31:0] rd1, rd2, rf_wd, addr_c;
    logic        rf_we, req_c, we_c, retire_c, bad_enc, bad, taken;
    alu_op_t     alu_op;

    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    riscv_mc_regfile #(.NREGS(NREGS)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .ra1     (instr[15 +: RW]),
        .ra2     (instr[20 +: RW]),
        .rd1     (rd1),
        .rd2     (rd2),
        .we      (rf_we),
        .wa      (instr[7 +: RW]),
        .wd      (rf_wd)
    );

    always_comb begin
        bad_enc = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE: bad_enc = (funct3 != 3'b010);
            OP_R, OP_I:        bad_enc = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
            OP_BRANCH:         bad_enc = (funct3[2:1] != 2'b00);
            OP_LUI, OP_JAL:    bad_enc = 1'b0;
            default:           bad_enc = 1'b1;
        endcase
    end

`ifdef RISCV_ILLEGAL_TRAP_EN
    localparam logic [5:0] NR = 6'(NREGS);
    logic bad_reg;

    always_comb begin
        bad_reg = 1'b0;
        if (opcode != OP_STORE && opcode != OP_BRANCH && {1'b0, instr[11:7]} >= NR)
            bad_reg = 1'b1;
        if (opcode != OP_LUI && opcode != OP_JAL && {1'b0, instr[19:15]} >= NR)
            bad_reg = 1'b1;
        if ((opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH) &&
            {1'b0, instr[24:20]} >= NR)
            bad_reg = 1'b1;
    end

    assign bad = bad_enc | bad_reg;

    logic illegal_q;
    always_ff @(posedge clk) begin
        if (!reset_n)
            illegal_q <= 1'b0;
        else if (state == DECODE && bad)
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign bad     = bad_enc;
    assign illegal = 1'b0;
`endif

    always_comb begin
        case (funct3)
            3'b111:  alu_op = AND;
            3'b110:  alu_op = OR;
            3'b010:  alu_op = SLT;
            default: alu_op = (opcode == OP_R && instr[30]) ? SUB : ADD;
        endcase
    end

    assign taken = funct3[0] ? (a_reg != b_reg) : (a_reg == b_reg);

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = alu_out;
        retire_c   = 1'b0;
        rf_we      = 1'b0;
        rf_wd      = alu_out;
        case (state)
            FETCH: begin
                req_c  = 1'b1;
                addr_c = pc;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                if (bad) begin
`ifdef RISCV_ILLEGAL_TRAP_EN
                    next_state = HALT;
`else
                    next_state = FETCH;
                    retire_c   = 1'b1;
`endif
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: next_state = MEMADR;
                        OP_R:              next_state = EXECR;
                        OP_I:              next_state = EXECI;
                        OP_LUI:            next_state = LUI;
                        OP_BRANCH:         next_state = BRANCH;
                        OP_JAL:            next_state = JAL;
                        default:           next_state = FETCH;
                    endcase
                end
            end
            MEMADR:   next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                req_c = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                rf_we      = 1'b1;
                rf_wd      = data_reg;
                retire_c   = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                req_c = 1'b1;
                we_c  = 1'b1;
                if (mem_ready) begin
                    retire_c   = 1'b1;
                    next_state = FETCH;
                end
            end
            EXECR, EXECI, LUI: next_state = ALUWB;
            ALUWB: begin
                rf_we      = 1'b1;
                retire_c   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                retire_c   = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                rf_we      = 1'b1;
                rf_wd      = old_pc + 32'd4;
                retire_c   = 1'b1;
                next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            old_pc   <= '0;
            instr    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_out  <= '0;
            data_reg <= '0;
        end else begin
            case (state)
                FETCH: if (mem_ready) begin
                    instr  <= mem_rdata;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                end
                DECODE: begin
                    a_reg <= rd1;
                    b_reg <= rd2;
                    if (opcode == OP_JAL)
                        alu_out <= old_pc + immext(J, instr[31:7]);
                    else
                        alu_out <= old_pc + immext(B, instr[31:7]);
                end
                MEMADR: begin
                    if (opcode == OP_STORE)
                        alu_out <= a_reg + immext(S, instr[31:7]);
                    else
                        alu_out <= a_reg + immext(I, instr[31:7]);
                end
                MEMREAD: if (mem_ready) data_reg <= mem_rdata;
                EXECR:   alu_out <= alu(alu_op, a_reg, b_reg);
                EXECI:   alu_out <= alu(alu_op, a_reg, immext(I, instr[31:7]));
                LUI:     alu_out <= immext(U, instr[31:7]);
                BRANCH:  if (taken) pc <= alu_out;
                JAL:     pc <= alu_out;
                default: ;
            endcase
        end
    end

    // Gating with reset_n keeps the port idle for the whole reset cycle, so an
    // access in flight when reset arrives can never complete.
    assign mem_req   = req_c & reset_n;
    assign mem_we    = we_c & reset_n;
    assign mem_addr  = addr_c;
    assign mem_wdata = b_reg;
    assign retire    = retire_c & reset_n;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed-program bench for riscv_multicycle (RV32E build, 1 KB memory model with wait states).
module tb_riscv_multicycle;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] JLOOP    = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req, mem_we, mem_ready, retire, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    int          total = 0;
    int          bad   = 0;
    int          ready_mode;
    int          edges = 0;
    int          st_count = 0;
    logic [31:0] st_addr, st_data;
    int          ret_q [$];
    logic [31:0] acc_q [$];
    logic        stall_prev = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;

    riscv_multicycle #(.RESET_PC(RESET_PC), .NREGS(16)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .retire    (retire),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xr(input int i);
        return u_dut.u_rf.regs[i];
    endfunction

    // mode 0: always ready, 1: random, 2: stall every store
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            1:       mem_ready = 1'($urandom_range(0, 1));
            2:       mem_ready = !mem_we;
            default: mem_ready = 1'b1;
        endcase
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            acc_q.delete();
            ret_q.delete();
            st_count = 0;
            edges    = 0;
        end else begin
            if (retire) ret_q.push_back(edges + 1);
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    st_count++;
                    st_addr = mem_addr;
                    st_data = mem_wdata;
                end else begin
                    acc_q.push_back(mem_addr);
                end
            end
            edges++;
        end
    end

    always @(negedge clk) begin
        if (reset_n && mem_req && stall_prev) begin
            check_eq("hold_addr", mem_addr, p_addr);
            check_eq("hold_we", {31'b0, mem_we}, {31'b0, p_we});
            check_eq("hold_wdata", mem_wdata, p_wdata);
        end
        stall_prev = reset_n && mem_req && !mem_ready;
        p_addr     = mem_addr;
        p_we       = mem_we;
        p_wdata    = mem_wdata;
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = JLOOP;
        mem[16] = '0;
        mem[25] = '0;
    endtask

    task automatic rst_begin();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic rst_end();
        check_eq("rst_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_we", {31'b0, mem_we}, 32'd0);
        check_eq("rst_retire", {31'b0, retire}, 32'd0);
        check_eq("rst_illegal", {31'b0, illegal}, 32'd0);
        reset_n = 1'b1;
        #1;
        check_eq("rst_fetch_req", {31'b0, mem_req}, 32'd1);
        check_eq("rst_fetch_pc", mem_addr, RESET_PC);
    endtask

    task automatic wait_ret(input int n, input int budget);
        int k = 0;
        while (ret_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (ret_q.size() < n) check_eq("retire_timeout", 32'(ret_q.size()), 32'(n));
        @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        mem_ready  = 1'b1;
        ready_mode = 0;

        // T1: addi/addi/add/sw with zero-wait memory
        rst_begin();
        clear_mem();
        mem[0] = 32'h00500113;
        mem[1] = 32'h01400193;
        mem[2] = 32'h00310233;
        mem[3] = 32'h06402223;
        rst_end();
        wait_ret(4, 100);
        for (int i = 0; i < 4; i++) check_eq("t1_retire_cyc", 32'(ret_q[i]), 32'(4 * (i + 1)));
        check_eq("t1_x4", xr(4), 32'd25);
        check_eq("t1_st_addr", st_addr, 32'h64);
        check_eq("t1_st_data", st_data, 32'd25);
        check_eq("t1_st_count", 32'(st_count), 32'd1);
        check_eq("t1_mem", mem[25], 32'd25);

        // T2: same program under random wait states
        rst_begin();
        ready_mode = 1;
        clear_mem();
        mem[0] = 32'h00500113;
        mem[1] = 32'h01400193;
        mem[2] = 32'h00310233;
        mem[3] = 32'h06402223;
        rst_end();
        wait_ret(4, 400);
        check_eq("t2_x2", xr(2), 32'd5);
        check_eq("t2_x3", xr(3), 32'd20);
        check_eq("t2_x4", xr(4), 32'd25);
        check_eq("t2_mem", mem[25], 32'd25);
        check_eq("t2_st_count", 32'(st_count), 32'd1);

        // T3: beq taken, bne not taken
        rst_begin();
        ready_mode = 0;
        clear_mem();
        mem[0] = 32'h00000463;
        mem[2] = 32'h00001463;
        mem[3] = JLOOP;
        rst_end();
        wait_ret(2, 50);
        check_eq("t3_beq_cyc", 32'(ret_q[0]), 32'd3);
        check_eq("t3_bne_cyc", 32'(ret_q[1]), 32'd6);
        check_eq("t3_beq_target", acc_q[1], 32'd8);
        check_eq("t3_bne_fallthru", acc_q[2], 32'd12);

        // T4: lui then backward jal
        rst_begin();
        clear_mem();
        mem[0] = 32'h123452B7;
        mem[1] = 32'hFFDFF0EF;
        rst_end();
        wait_ret(2, 50);
        check_eq("t4_x5", xr(5), 32'h12345000);
        check_eq("t4_x1", xr(1), 32'd8);
        check_eq("t4_jal_cyc", 32'(ret_q[1]), 32'd7);
        check_eq("t4_jal_target", acc_q[2], 32'd0);

        // T5: reset during a stalled store
        rst_begin();
        ready_mode = 2;
        clear_mem();
        mem[0] = 32'h05500313;
        mem[1] = 32'h04602023;
        rst_end();
        for (int k = 0; k < 40 && !(mem_req && mem_we); k++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("t5_stall_req", {31'b0, mem_req && mem_we}, 32'd1);
        check_eq("t5_stall_addr", mem_addr, 32'd64);
        check_eq("t5_stall_wdata", mem_wdata, 32'h55);
        reset_n = 1'b0;
        #1;
        check_eq("t5_req_drop", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        ready_mode = 0;
        check_eq("t5_no_store", 32'(st_count), 32'd0);
        check_eq("t5_mem", mem[16], 32'd0);
        check_eq("t5_x6_cleared", xr(6), 32'd0);
        rst_end();

        // T8: jal to 0xFFFFFFFC, PC wraps to 0
        rst_begin();
        clear_mem();
        mem[0]   = 32'hFFDFF06F;
        mem[255] = 32'h00100393;
        rst_end();
        wait_ret(2, 50);
        check_eq("t8_top_fetch", acc_q[1], 32'hFFFF_FFFC);
        check_eq("t8_wrap_fetch", acc_q[2], 32'd0);
        check_eq("t8_x7", xr(7), 32'd1);

        // T9: ALU ops, slti, lw, andi, ori with random waits
        rst_begin();
        ready_mode = 1;
        clear_mem();
        mem[0]  = 32'hFFD00093;
        mem[1]  = 32'h00500113;
        mem[2]  = 32'h401101B3;
        mem[3]  = 32'h0020A233;
        mem[4]  = 32'h0020F2B3;
        mem[5]  = 32'h0020E333;
        mem[6]  = 32'hFFF12393;
        mem[7]  = 32'h06402403;
        mem[8]  = 32'h12306493;
        mem[9]  = 32'h00F0F513;
        mem[25] = 32'hCAFEF00D;
        rst_end();
        wait_ret(10, 600);
        check_eq("t9_addi_neg", xr(1), 32'hFFFF_FFFD);
        check_eq("t9_sub", xr(3), 32'd8);
        check_eq("t9_slt", xr(4), 32'd1);
        check_eq("t9_and", xr(5), 32'd5);
        check_eq("t9_or", xr(6), 32'hFFFF_FFFD);
        check_eq("t9_slti", xr(7), 32'd0);
        check_eq("t9_lw", xr(8), 32'hCAFEF00D);
        check_eq("t9_ori", xr(9), 32'h123);
        check_eq("t9_andi", xr(10), 32'hD);

        // T6: add x17 on the 16-register build
        rst_begin();
        ready_mode = 0;
        clear_mem();
        mem[0] = 32'h00300093;
        mem[1] = 32'h00400113;
        mem[2] = 32'h002088B3;
        rst_end();
`ifdef RISCV_ILLEGAL_TRAP_EN
        wait_ret(2, 50);
        repeat (6) @(negedge clk);
        check_eq("t6_illegal", {31'b0, illegal}, 32'd1);
        check_eq("t6_retires", 32'(ret_q.size()), 32'd2);
        for (int k = 0; k < 4; k++) begin
            check_eq("t6_halt_req", {31'b0, mem_req}, 32'd0);
            @(negedge clk);
        end
`else
        wait_ret(3, 50);
        check_eq("t6_retire_cyc", 32'(ret_q[2]), 32'd12);
        check_eq("t6_next_fetch", acc_q[3], 32'd12);
        check_eq("t6_x1_trunc", xr(1), 32'd7);
        check_eq("t6_illegal", {31'b0, illegal}, 32'd0);
`endif

        // T7: unknown opcode
        rst_begin();
        clear_mem();
        mem[0] = 32'hFFFFFFFF;
        rst_end();
`ifdef RISCV_ILLEGAL_TRAP_EN
        repeat (8) @(negedge clk);
        check_eq("t7_illegal", {31'b0, illegal}, 32'd1);
        check_eq("t7_retires", 32'(ret_q.size()), 32'd0);
        check_eq("t7_halt_req", {31'b0, mem_req}, 32'd0);
`else
        wait_ret(1, 50);
        check_eq("t7_nop_cyc", 32'(ret_q[0]), 32'd2);
        check_eq("t7_next_fetch", acc_q[1], 32'd4);
        check_eq("t7_illegal", {31'b0, illegal}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
